// File: rtl/goc_pwm_tx.sv
// goc_pwm_tx: GOC pulse-width line encoder fed from a show-ahead FIFO
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   fifo_din      FIFO head: [7:0] data byte, [8] marker (popped, not sent)
//   fifo_empty    high when the FIFO has no entry
//   fifo_RE       pop strobe, high for the LOAD cycle that consumes the head
//   start_tx      one-cycle frame start request (ignored while busy)
//   base_counter  phase length minus one in clocks (0 behaves as 1)
//   PWM_OUT       registered GOC line, idle low
//   busy          high whenever the FSM is outside IDLE
//   tx_done       one-cycle pulse in the cycle after DONE
//
// Each bit is three phases of P clocks: '1' = H H L, '0' = H L L, MSB first.
// Optional build macro GOC_PREAMBLE_EN adds a run of PREAMBLE_BITS '1' bits
// before the first byte.
module goc_pwm_tx #(
    parameter int PREAMBLE_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  fifo_din,
    input  logic        fifo_empty,
    output logic        fifo_RE,
    input  logic        start_tx,
    input  logic [21:0] base_counter,
    output logic        PWM_OUT,
    output logic        busy,
    output logic        tx_done
);
    // One bit counter serves both the byte and the preamble run.
    localparam int CW = $clog2(PREAMBLE_BITS > 8 ? PREAMBLE_BITS : 8);

    typedef enum logic [2:0] {
        IDLE,
`ifdef GOC_PREAMBLE_EN
        PREAMBLE,
`endif
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [21:0]   plen;
    logic [21:0]   pcnt;
    logic [1:0]    ph;
    logic [CW-1:0] bcnt;
    logic [7:0]    sreg;
    logic          cur_bit;
    logic          phase_end;
    logic          stream_end;

`ifdef GOC_PREAMBLE_EN
    assign cur_bit = state == PREAMBLE || sreg[7];
`else
    assign cur_bit = sreg[7];
`endif
    // plen holds P-1, already clamped to at least 1.
    assign phase_end = pcnt == plen;
    // LOAD takes the place of the final low clock of a bit stream, so the
    // stream hands over one clock early and bytes follow with no gap.
    assign stream_end = ph == 2'd2 && bcnt == '0 && pcnt == plen - 22'd1;
    assign fifo_RE = state == LOAD && !fifo_empty && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            PWM_OUT <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            plen    <= '0;
            pcnt    <= '0;
            ph      <= '0;
            bcnt    <= '0;
            sreg    <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (start_tx) begin
                    plen <= base_counter == '0 ? 22'd1 : base_counter;
                    busy <= 1'b1;
                    pcnt <= '0;
                    ph   <= '0;
`ifdef GOC_PREAMBLE_EN
                    bcnt    <= CW'(PREAMBLE_BITS - 1);
                    PWM_OUT <= 1'b1;
                    state   <= PREAMBLE;
`else
                    state <= LOAD;
`endif
                end
                LOAD: if (fifo_empty) begin
                    state <= DONE;
                end else if (!fifo_din[8]) begin
                    state   <= SHIFT;
                    sreg    <= fifo_din[7:0];
                    bcnt    <= CW'(7);
                    pcnt    <= '0;
                    ph      <= '0;
                    PWM_OUT <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tx_done <= 1'b1;
                end
                default: if (stream_end) begin
                    state <= LOAD;
                end else if (!phase_end) begin
                    pcnt <= pcnt + 22'd1;
                end else begin
                    pcnt <= '0;
                    if (ph == 2'd2) begin
                        ph      <= '0;
                        bcnt    <= bcnt - 1'b1;
                        sreg    <= {sreg[6:0], 1'b0};
                        PWM_OUT <= 1'b1;
                    end else begin
                        ph      <= ph + 2'd1;
                        PWM_OUT <= ph == 2'd0 && cur_bit;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_goc_pwm_tx.sv
// tb_goc_pwm_tx: directed bench for goc_pwm_tx with a per-cycle reference model
module tb_goc_pwm_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  fifo_din = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_RE;
    logic        start_tx = 1'b0;
    logic [21:0] base_counter = 22'd1;
    logic        PWM_OUT;
    logic        busy;
    logic        tx_done;

    always #5 clk = ~clk;

    goc_pwm_tx #(.PREAMBLE_BITS(4)) dut (
        .clk(clk),
        .reset(reset),
        .fifo_din(fifo_din),
        .fifo_empty(fifo_empty),
        .fifo_RE(fifo_RE),
        .start_tx(start_tx),
        .base_counter(base_counter),
        .PWM_OUT(PWM_OUT),
        .busy(busy),
        .tx_done(tx_done)
    );

    // Leading samples of a frame: the first LOAD clock, or the preamble whose
    // last low clock is that LOAD.
`ifdef GOC_PREAMBLE_EN
    localparam int PB = 4;
    localparam logic [127:0] LEAD = 128'hF3CF3C;
    localparam int LW = 24;
    localparam int B5_BUSY = 217;
`else
    localparam logic [127:0] LEAD = 128'h0;
    localparam int LW = 1;
    localparam int B5_BUSY = 146;
`endif
    // Byte waveforms at P=2, MSB first.
    localparam logic [127:0] W_A5 = 128'hF30F30C3CC3C;
    localparam logic [127:0] W_3C = 128'hC30F3CF3CC30;
    localparam logic [127:0] W_AA = 128'hF30F30F30F30;
    localparam logic [127:0] W_00 = 128'hC30C30C30C30;

    int total = 0;
    int bad = 0;
    logic [8:0] fifo_q[$];
    logic [3:0] eq[$];
    logic [3:0] cur = 4'b0;
    logic [3:0] act;
    logic [3:0] exp;
    logic       armed = 1'b0;
    logic       pop_now;
    logic [127:0] vec;
    int busy_cnt, re_cnt, done_cnt;

    task automatic fifo_sync();
        fifo_empty = fifo_q.size() == 0;
        fifo_din = fifo_empty ? 9'h0 : fifo_q[0];
    endtask

    // Expected entries are {pwm, fifo_RE, busy, tx_done} per clock.
    function automatic void push_bit(logic b, int p);
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < p; k++)
                eq.push_back({s == 0 || (s == 1 && b), 3'b010});
    endfunction

    function automatic void mark_pop();
        logic [3:0] e;
        e = eq.pop_back();
        e[2] = 1'b1;
        eq.push_back(e);
    endfunction

    function automatic void build();
        int p;
        p = (base_counter == 0 ? 1 : int'(base_counter)) + 1;
        eq.delete();
`ifdef GOC_PREAMBLE_EN
        for (int n = 0; n < PB; n++) push_bit(1'b1, p);
`else
        eq.push_back(4'b0010);
`endif
        foreach (fifo_q[i]) begin
            mark_pop();
            if (fifo_q[i][8]) eq.push_back(4'b0010);
            else for (int b = 7; b >= 0; b--) push_bit(fifo_q[i][b], p);
        end
        eq.push_back(4'b0010);
        eq.push_back(4'b0001);
    endfunction

    always @(posedge clk) begin
        pop_now = fifo_RE;
        if (reset) begin
            eq.delete();
            cur = 4'b0;
            armed = 1'b1;
        end else begin
            if (!cur[1] && start_tx) build();
            if (eq.size() > 0) cur = eq.pop_front();
            else cur = 4'b0;
        end
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            fifo_sync();
        end
    end

    always @(negedge clk) if (armed) begin
        act = {PWM_OUT, fifo_RE, busy, tx_done};
        exp = {cur[3], cur[2] & ~reset, cur[1], cur[0]};
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL model_cycle t=%0t pwm/re/busy/done got %b want %b", $time, act, exp);
        end
        if (busy) begin
            vec = {vec[126:0], PWM_OUT};
            busy_cnt++;
        end
        re_cnt += int'(fifo_RE);
        done_cnt += int'(tx_done);
    end

    task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got %0h want %0h", nm, a, e);
        end
    endtask

    function automatic logic [127:0] wave(logic [127:0] mid, int w);
        return (LEAD << (w + 1)) | (mid << 1);
    endfunction

    task automatic clear_log();
        vec = '0;
        busy_cnt = 0;
        re_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic push(logic [8:0] d);
        fifo_q.push_back(d);
        fifo_sync();
    endtask

    task automatic start();
        clear_log();
        start_tx = 1'b1;
        @(posedge clk);
        #1 start_tx = 1'b0;
    endtask

    task automatic wait_done(string nm);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
        #1;
        chk({nm, "_timeout"}, 128'(done_cnt != 0), 128'd1);
    endtask

    task automatic check(string nm, logic [127:0] ev, int eb, int er);
        chk({nm, "_pwm"}, vec, ev);
        chk({nm, "_busy"}, 128'(busy_cnt), 128'(eb));
        chk({nm, "_re"}, 128'(re_cnt), 128'(er));
        chk({nm, "_done"}, 128'(done_cnt), 128'd1);
    endtask

    initial begin
        clear_log();
        repeat (3) @(posedge clk);
        #1 start_tx = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        start_tx = 1'b0;
        @(negedge clk);
        chk("rst_pwm", 128'(PWM_OUT), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_re", 128'(fifo_RE), 128'd0);
        chk("rst_done", 128'(tx_done), 128'd0);
        @(posedge clk);
        #1;

        push(9'h0A5);
        start();
        repeat (10) @(posedge clk);
        #1 start_tx = 1'b1;
        @(posedge clk);
        #1 start_tx = 1'b0;
        wait_done("a5");
        check("a5", wave(W_A5, 48), LW + 49, 1);

        push(9'h1FF);
        push(9'h03C);
        start();
        wait_done("marker");
        check("marker", wave(W_3C, 49), LW + 50, 2);

        start();
        @(posedge clk);
        #1 start_tx = 1'b1;
        @(posedge clk);
        #1 start_tx = 1'b0;
        wait_done("empty");
        check("empty", wave(128'h0, 0), LW + 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("empty_idle", 128'(busy), 128'd0);
        @(posedge clk);
        #1;

        base_counter = 22'd0;
        push(9'h0A5);
        start();
        repeat (5) @(posedge clk);
        #1 base_counter = 22'd5;
        wait_done("b0");
        check("b0", wave(W_A5, 48), LW + 49, 1);
        push(9'h080);
        start();
        wait_done("b5");
        chk("b5_busy", 128'(busy_cnt), 128'(B5_BUSY));

        base_counter = 22'd1;
        push(9'h0FF);
        push(9'h0AA);
        start();
        repeat (LW + 26) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_pwm", 128'(PWM_OUT), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        clear_log();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_re", 128'(re_cnt), 128'd0);
        chk("abort_fifo", 128'(fifo_q.size()), 128'd1);
        start();
        wait_done("after_rst");
        check("after_rst", wave(W_AA, 48), LW + 49, 1);

        push(9'h000);
        start();
        repeat (30) @(posedge clk);
        #1 start_tx = 1'b1;
        @(posedge clk);
        #1 start_tx = 1'b0;
        wait_done("zero");
        check("zero", wave(W_00, 48), LW + 49, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/goc_pwm_tx.md
GOC_PWM_TX -- requirements
Module: goc_pwm_tx

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 16, number of '1' bits sent before the first byte when the preamble is compiled in.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_din  input  9  show-ahead FIFO head: [7:0] data, [8] marker flag.
REQ-005 SHALL have port fifo_empty  input  1  high when no FIFO entry is available.
REQ-006 SHALL have port fifo_RE  output  1  one-cycle pop strobe.
REQ-007 SHALL have port start_tx  input  1  one-cycle frame start request.
REQ-008 SHALL have port base_counter  input  22  phase length minus one, in clocks.
REQ-009 SHALL have port PWM_OUT  output  1  encoded GOC line; idle low.
REQ-010 SHALL have port busy  output  1  high from start acceptance until frame end.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-012 SHALL use a state machine with states IDLE, PREAMBLE, LOAD, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start_tx high, latch base_counter into a 22-bit phase register and go to PREAMBLE if compiled in, else LOAD.
REQ-014 SHALL define phase length P = max(latched base_counter, 1) + 1 clocks; base_counter=0 behaves as 1.
REQ-015 SHALL make each bit three phases: '1' = high, high, low; '0' = high, low, low (3P clocks per bit).
REQ-016 SHALL send bits MSB first (bit 7 to bit 0) with no gap between bits or between bytes.
REQ-017 SHALL, in LOAD with fifo_empty low, assert fifo_RE for exactly that cycle and capture fifo_din in the same cycle.
REQ-018 SHALL, when the captured fifo_din[8]=1, transmit nothing for that entry and return to LOAD on the next cycle.
REQ-019 SHALL, when the captured fifo_din[8]=0, go to SHIFT and send the 8 data bits, then return to LOAD.
REQ-020 SHALL, in LOAD with fifo_empty high, go to DONE; the first PWM high of a byte starts the cycle after LOAD.
REQ-021 SHALL, in DONE, hold PWM_OUT low, pulse tx_done for one cycle and return to IDLE.
REQ-022 SHALL drive busy low only in IDLE.
REQ-023 SHALL ignore start_tx while busy, including start_tx coincident with the DONE cycle.
REQ-024 SHALL ignore base_counter changes during a frame; the latched value holds until the next start.
REQ-025 SHALL never assert fifo_RE while fifo_empty is high, nor outside LOAD.
REQ-026 SHALL register PWM_OUT (no combinational path from inputs).

Reset
REQ-027 SHALL, on reset, force state=IDLE, PWM_OUT=0, fifo_RE=0, busy=0, tx_done=0, phase/bit counters=0, on the next clock edge.
REQ-028 SHALL abort a frame in progress when reset is asserted mid-frame, without popping further entries.
REQ-029 SHALL give reset priority over start_tx in the same cycle.

Configuration
REQ-030 SHALL, with macro GOC_PREAMBLE_EN defined, enter PREAMBLE after start and send PREAMBLE_BITS '1' bits before the first LOAD.
REQ-031 SHALL, without GOC_PREAMBLE_EN, compile out the PREAMBLE state and its counter and go from IDLE directly to LOAD.

Verification
REQ-032 SHALL cover this case: preamble off, base_counter=1, FIFO={0x0A5}, start_tx.
- Required: PWM_OUT = 1 1 0 / 1 0 0 / 1 1 0 / 1 0 0 / 1 0 0 / 1 1 0 / 1 0 0 / 1 1 0 in 2-clock phases (48 clocks).
- Required: exactly one fifo_RE, then tx_done one cycle later.
REQ-033 SHALL cover this case: FIFO={0x1FF, 0x03C}.
- Required: the marker entry is popped with no PWM activity.
- Required: 0x3C is sent as 0,0,1,1,1,1,0,0.
- Required: two fifo_RE pulses in total.
REQ-034 SHALL cover this case: start_tx with FIFO empty.
- Required: PWM_OUT stays low, fifo_RE never asserts.
- Required: busy lasts 2 cycles (LOAD, DONE), then tx_done pulses.
REQ-035 SHALL cover this case: base_counter=0 versus base_counter=1.
- Required: identical waveforms (P=2).
- Required: base_counter changed to 5 mid-frame has no effect until the next start.
REQ-036 SHALL cover this case: reset asserted during bit 3 of a byte.
- Required: PWM_OUT=0 and busy=0 the next cycle.
- Required: no further fifo_RE; a later start_tx transmits normally.
REQ-037 SHALL cover this case: GOC_PREAMBLE_EN defined, PREAMBLE_BITS=4, base_counter=1, FIFO={0x000}.
- Required: four '1' bits (24 clocks), then eight '0' bits.
- Required: start_tx pulsed mid-frame is ignored.
